// File: rtl/fft_frame_serializer.sv
// Ping-pong frame buffer that turns one parallel FFT result into a valid/ready
// stream of N bins, in natural or bit-reversed read order. Each bin is {re, im}.
module fft_frame_serializer #(
    parameter int N           = 128,
    parameter int BIT_REVERSE = 0,
    parameter int DATA_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N*2*DATA_W-1:0]     in_frame,
    input  logic                      in_valid,
    output logic [2*DATA_W-1:0]       out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(N)-1:0]      out_index,
    output logic                      out_last,
    output logic                      overflow,
    output logic                      busy
);
    localparam int IDX_W = $clog2(N);
    localparam int W     = 2 * DATA_W;

    logic [W-1:0]     bank_q [2][N];
    logic [W-1:0]     bank_d [2][N];
    logic [1:0]       full_q, full_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overflow_q, overflow_d;

    logic             xfer, done, free, capture;
    logic [IDX_W-1:0] rd_idx;

    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int b = 0; b < IDX_W; b++) begin
            r[b] = v[IDX_W-1-b];
        end
        return r;
    endfunction

    always_comb begin
        out_valid = full_q[rd_sel_q];
        rd_idx    = (BIT_REVERSE != 0) ? bitrev(idx_q) : idx_q;
        out_data  = out_valid ? bank_q[rd_sel_q][rd_idx] : '0;
        out_index = idx_q;
        out_last  = out_valid && (idx_q == IDX_W'(N - 1));
        overflow  = overflow_q;
        busy      = full_q[0] | full_q[1];
    end

    always_comb begin
        xfer    = out_valid & out_ready;
        done    = xfer && (idx_q == IDX_W'(N - 1));
        // The bank being drained counts as free on its final handshake.
        free    = !full_q[wr_sel_q] || ((wr_sel_q == rd_sel_q) && done);
        capture = in_valid && free;

        bank_d     = bank_q;
        full_d     = full_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;

        if (xfer) begin
            idx_d = idx_q + 1'b1;
        end
        if (done) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
        // Capture is applied after done so a freed bank can be refilled at once.
        if (capture) begin
            for (int j = 0; j < N; j++) begin
                bank_d[wr_sel_q][j] = in_frame[j*W +: W];
            end
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end else if (in_valid) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q     <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Frame storage is data only; validity is carried entirely by full_q.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Randomized and directed bench for fft_frame_serializer (N=8), natural and
// bit-reversed instances side by side, checked against a frame-queue model.
module tb_fft_frame_serializer;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int W  = 2 * DW;
    localparam int IW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_frame;
    logic           in_valid;
    logic           out_ready;

    logic [W-1:0]  od0, od1;
    logic          ov0, ov1, ol0, ol1, of0, of1, bz0, bz1;
    logic [IW-1:0] oi0, oi1;

    int n_vec = 0;
    int n_err = 0;

    logic [N*W-1:0] fq[$];
    int             pos;
    logic           m_ovf;

    always #5 clk = ~clk;

    fft_frame_serializer #(.N(N), .BIT_REVERSE(0), .DATA_W(DW)) dut_nat (
        .clk(clk), .reset(reset), .in_frame(in_frame), .in_valid(in_valid),
        .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
        .out_index(oi0), .out_last(ol0), .overflow(of0), .busy(bz0)
    );

    fft_frame_serializer #(.N(N), .BIT_REVERSE(1), .DATA_W(DW)) dut_br (
        .clk(clk), .reset(reset), .in_frame(in_frame), .in_valid(in_valid),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
        .out_index(oi1), .out_last(ol1), .overflow(of1), .busy(bz1)
    );

    function automatic logic [W-1:0] word_of(input logic [N*W-1:0] f, input int k);
        return f[k*W +: W];
    endfunction

    // Bit reversal over 3 bits, written as the index permutation.
    function automatic int brev(input int k);
        int perm [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        return perm[k];
    endfunction

    function automatic logic [N*W-1:0] ramp_frame(input int base, input logic neg_im);
        logic [N*W-1:0] f;
        for (int j = 0; j < N; j++) begin
            f[j*W +: W] = {16'(base + j), neg_im ? 16'(-j) : 16'(0)};
        end
        return f;
    endfunction

    function automatic logic [N*W-1:0] rand_frame();
        logic [N*W-1:0] f;
        for (int j = 0; j < N; j++) begin
            f[j*W +: W] = $urandom;
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge: drive, check presented state, advance model.
    task automatic step(input logic iv, input logic [N*W-1:0] f, input logic rdy);
        logic           v;
        logic [N*W-1:0] cur;
        in_valid  = iv;
        in_frame  = f;
        out_ready = rdy;
        #1;
        v = (fq.size() > 0);
        chk("valid",    32'(ov0), 32'(v));
        chk("valid_br", 32'(ov1), 32'(v));
        chk("busy",     32'(bz0), 32'(v));
        chk("busy_br",  32'(bz1), 32'(v));
        chk("overflow", 32'(of0), 32'(m_ovf));
        chk("overflow_br", 32'(of1), 32'(m_ovf));
        if (v) begin
            cur = fq[0];
            chk("data",     32'(od0), 32'(word_of(cur, pos)));
            chk("data_br",  32'(od1), 32'(word_of(cur, brev(pos))));
            chk("index",    32'(oi0), 32'(pos));
            chk("index_br", 32'(oi1), 32'(pos));
            chk("last",     32'(ol0), 32'(pos == N - 1));
            chk("last_br",  32'(ol1), 32'(pos == N - 1));
        end else begin
            chk("last_idle", 32'(ol0), 32'(0));
        end
        if (v && rdy) begin
            pos++;
            if (pos == N) begin
                void'(fq.pop_front());
                pos = 0;
            end
        end
        if (iv) begin
            if (fq.size() < 2) fq.push_back(f);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles, input logic rdy);
        for (int c = 0; c < cycles; c++) step(1'b0, '0, rdy);
    endtask

    // Reset is asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_valid",    32'(ov0), 32'(0));
        chk("rst_busy",     32'(bz0), 32'(0));
        chk("rst_overflow", 32'(of0), 32'(0));
        chk("rst_index",    32'(oi0), 32'(0));
        chk("rst_data",     32'(od0), 32'(0));
        chk("rst_last",     32'(ol0), 32'(0));
        chk("rst_valid_br", 32'(ov1), 32'(0));
        fq.delete();
        pos   = 0;
        m_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic injected;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_frame  = '0;
        pos       = 0;
        m_ovf     = 1'b0;
        @(negedge clk);
        do_reset();

        // Single frame (j, -j), continuous ready.
        step(1'b1, ramp_frame(0, 1'b1), 1'b1);
        idle(10, 1'b1);

        // Backpressure pattern 1,0,0 repeating.
        step(1'b1, ramp_frame(50, 1'b0), 1'b1);
        for (int c = 0; c < 30; c++) step(1'b0, '0, (c % 3) == 0);

        // Ping-pong: frame B three cycles after frame A.
        step(1'b1, ramp_frame(100, 1'b0), 1'b1);
        idle(2, 1'b1);
        step(1'b1, ramp_frame(200, 1'b0), 1'b1);
        idle(18, 1'b1);
        chk("pingpong_ovf", 32'(of0), 32'(0));

        // Overflow: three strobes while stalled; C must be lost.
        step(1'b1, ramp_frame(300, 1'b0), 1'b0);
        step(1'b1, ramp_frame(400, 1'b0), 1'b0);
        step(1'b1, ramp_frame(500, 1'b0), 1'b0);
        idle(1, 1'b0);
        chk("ovf_after_c", 32'(of0), 32'(1));
        idle(20, 1'b1);

        // Third strobe lands on frame A's final handshake.
        do_reset();
        step(1'b1, ramp_frame(600, 1'b0), 1'b1);
        step(1'b1, ramp_frame(700, 1'b0), 1'b1);
        injected = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (!injected && fq.size() == 2 && pos == N - 1) begin
                injected = 1'b1;
                step(1'b1, ramp_frame(800, 1'b0), 1'b1);
            end else begin
                step(1'b0, '0, 1'b1);
            end
        end
        chk("boundary_ovf", 32'(of0), 32'(0));

        // Random traffic and ready.
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 5) == 0, rand_frame(), $urandom_range(0, 3) != 0);
        end

        // Reset mid-drain, then a fresh stream from bin 0.
        step(1'b1, ramp_frame(900, 1'b0), 1'b1);
        idle(3, 1'b1);
        do_reset();
        step(1'b1, ramp_frame(1000, 1'b1), 1'b1);
        idle(10, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1);
    end
endmodule

// File: doc/fft_frame_serializer.md
# fft_frame_serializer

Frame-to-stream converter placed directly downstream of `fft_N_rad2`. Captures the N-wide parallel `fft_out` vector when the FFT raises its one-cycle `out_valid`, then streams the N bins out one per cycle over a valid/ready handshake in natural or bit-reversed index order. Two internal frame banks (ping-pong) let the next FFT frame land while the current one drains, so the stream side sustains one bin per cycle. Its output feeds the per-subcarrier stages (equalizer/demapper) and file-dump benches.

## Interface
- `N`, 128, FFT size; power of two, ≥ 4; must match the upstream FFT.
- `BIT_REVERSE`, 0, 0: bin k is emitted from input index k; 1: bin k is emitted from input index bitrev(k) over log2(N) bits.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserted when 0.
- `in_frame`  in  complex_product_t [N-1:0]  parallel FFT result (connects to `fft_out`).
- `in_valid`  in  1  frame strobe (connects to FFT `out_valid`); an X value counts as 0.
- `out_data`  out  complex_product_t  current streamed bin.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_index`  out  $clog2(N)  bin number k of `out_data` (natural order, 0..N-1).
- `out_last`  out  1  high with the bin where k = N-1.
- `overflow`  out  1  sticky: a frame was dropped because both banks were full.
- `busy`  out  1  at least one bank holds an undrained frame.

## Operation
- State: `bank[2][N]`, `full[2]`, `wr_sel`, `rd_sel`, `idx` (log2(N) bits), `overflow`.
- Reset (async, `reset` = 0): `full` = 0,0; `wr_sel` = `rd_sel` = 0; `idx` = 0; `overflow` = 0. Outputs: `out_valid` 0, `out_data` 0 (both fields), `out_index` 0, `out_last` 0, `busy` 0. Bank contents need not be cleared. Reset mid-frame discards both banks; no partial frame survives.
- Handshake `xfer` = `out_valid` & `out_ready`; `done` = `xfer` & (`idx` == N-1).
- Bank `wr_sel` counts as free if `!full[wr_sel]`, or if `wr_sel` == `rd_sel` and `done` is true this cycle.
- Capture: `in_valid` & free → copy all N words of `in_frame` into `bank[wr_sel]`, set `full[wr_sel]`, toggle `wr_sel`.
- Drop: `in_valid` & not free → frame ignored, `overflow` ← 1 (cleared only by reset), no other state changes.
- Drain: `out_valid` = `full[rd_sel]`. `out_data` = `bank[rd_sel][BIT_REVERSE ? bitrev(idx) : idx]`. `out_index` = `idx`. `out_last` = `out_valid` & (`idx` == N-1).
- On `xfer`: `idx` ← `idx`+1 (wraps to 0 after N-1). On `done`: clear `full[rd_sel]` and toggle `rd_sel`.
- Capture and `done` in the same cycle both take effect, including into the bank being freed.
- `busy` = `full[0]` | `full[1]`.
- Data passes unmodified: no scaling, rounding or width change.

## Timing
- Latency: `in_valid` at edge t (banks empty) → `out_valid` = 1 with bin 0 in the cycle after edge t.
- Under continuous `out_ready`: N bins in N consecutive cycles; back-to-back frames stream with no bubble.
- While `out_valid` & !`out_ready`: `out_data`, `out_index` and `out_last` hold stable, and `out_valid` stays high.
- `out_ready` may toggle freely; it has no effect while `out_valid` is 0.
- Capturing a new frame never changes the bin currently presented.
- Upstream FFT spacing ≥ N cycles, with `out_ready` held high, never overflows.

## Test plan
- N=8, BIT_REVERSE=0, `out_ready`=1: frame `in_frame[j]` = (j, −j) strobed once → next 8 cycles emit (0,0),(1,−1)…(7,−7), with `out_index` 0..7 and `out_last` only on (7,−7); then `busy` = 0.
- N=8, BIT_REVERSE=1: same frame → emitted r values 0,4,2,6,1,5,3,7, with `out_index` still 0..7.
- Backpressure: `out_ready` toggles 1,0,0,1,… → every bin appears exactly once, in order, and `out_data` is held on the stall cycles.
- Ping-pong: frame A (r = 100+j), then frame B (r = 200+j) 3 cycles later, `out_ready`=1 → 16 contiguous bins A0..A7, B0..B7, with `overflow` = 0.
- Overflow: `out_ready`=0, three strobes (A, B, C) → `overflow` = 1 after C. Releasing `out_ready` then emits A, B only; C is lost.
- Boundary/reset: third strobe coincident with the `done` of frame A is captured (no overflow). `reset` pulled low mid-drain → `out_valid`, `busy`, `overflow` go 0 immediately, and the next stream starts at bin 0.
